uart_tx_frame: RTL and testbench

//  Serializes one parallel word into a UART frame on tx_out: start, DATA_WIDTH data bits LSB first,

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_frame_if.sv | 21 ++
 rtl/uart_tx_baud_cnt.sv | 27 ++
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line levels used by TX and the RX checkers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/status bundle of the UART transmitter; par_typ exists only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
`ifdef UART_TX_PARITY_EN
   logic                  par_typ;
`endif
   logic                  tx_out;
   logic                  busy;
   logic                  done;

`ifdef UART_TX_PARITY_EN
   modport master (output p_data, data_valid, par_typ, input tx_out, busy, done);
   modport slave  (input p_data, data_valid, par_typ, output tx_out, busy, done);
`else
   modport master (output p_data, data_valid, input tx_out, busy, done);
   modport slave  (input p_data, data_valid, output tx_out, busy, done);
`endif
endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_tx_baud_cnt #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic bit_tick
);

   logic [CNT_W-1:0] clk_cnt;

   assign bit_tick = en && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_cnt <= '0;
      end else if (clr || bit_tick) begin
         clk_cnt <= '0;
      end else if (en) begin
         clk_cnt <= clk_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity (UART_TX_PARITY_EN), stop.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 5
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_frame_if.slave bus
);

   localparam int BI_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_e           state_q;
   uart_state_e           state_nxt;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [BI_W-1:0]       bit_idx_q;
   logic                  accept;
   logic                  bit_tick;
   logic                  last_bit;
   logic                  tx_d;
   logic                  busy_d;
   logic                  done_d;
`ifdef UART_TX_PARITY_EN
   logic                  par_q;
`endif

   assign accept   = (state_q == ST_IDLE) && bus.data_valid;
   assign last_bit = (bit_idx_q == BI_W'(DATA_WIDTH - 1));

   uart_tx_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en       (state_q != ST_IDLE),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:   if (accept)   state_nxt = ST_START;
         ST_START:  if (bit_tick) state_nxt = ST_DATA;
         ST_DATA: begin
            if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = ST_PARITY;
`else
               state_nxt = ST_STOP;
`endif
            end
         end
         ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
         ST_STOP:   if (bit_tick) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so the registered line level switches on the boundary edge.
   always_comb begin
      shift_nxt = shift_q;
      if (accept) begin
         shift_nxt = bus.p_data;
      end else if ((state_q == ST_DATA) && bit_tick) begin
         shift_nxt = shift_q >> 1;
      end

      tx_d = IDLE_LEVEL;
      case (state_nxt)
         ST_START:  tx_d = START_LEVEL;
         ST_DATA:   tx_d = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_q;
`else
         ST_PARITY: tx_d = STOP_LEVEL;
`endif
         ST_STOP:   tx_d = STOP_LEVEL;
         default:   tx_d = IDLE_LEVEL;
      endcase

      busy_d = (state_nxt != ST_IDLE);
      done_d = (state_q == ST_STOP) && bit_tick;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q     <= '0;
         bit_idx_q   <= '0;
         bus.tx_out  <= IDLE_LEVEL;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         shift_q    <= shift_nxt;
         bus.tx_out <= tx_d;
         bus.busy   <= busy_d;
         bus.done   <= done_d;
         if (accept) begin
            bit_idx_q <= '0;
         end else if ((state_q == ST_DATA) && bit_tick) begin
            bit_idx_q <= bit_idx_q + BI_W'(1);
         end
`ifdef UART_TX_PARITY_EN
         // Parity is fixed at accept time, so later p_data/par_typ changes cannot disturb it.
         if (accept) begin
            par_q <= (^bus.p_data) ^ bus.par_typ;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame shape, parity, back-to-back, busy-ignore, async reset, random RX scoreboard.
module tb_uart_tx_frame;

   localparam int CPB_A = 16;
   localparam int CPB_B = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int NB = PAR_EN ? 11 : 10;

   typedef struct packed {
      logic [7:0] d;
      logic       pt;
   } sb_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   sb_t  sbq[$];

   uart_tx_frame_if #(.DATA_WIDTH(8)) ifa ();
   uart_tx_frame_if #(.DATA_WIDTH(8)) ifb ();

   uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB_A), .CNT_W(5)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB_B), .CNT_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp_bit(input logic [7:0] d, input logic pt, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (PAR_EN && b == 9) return (^d) ^ pt;
      return 1'b1;
   endfunction

   // Drives one request on instance A; returns at the negedge of the first start-bit cycle.
   task automatic send_a(input logic [7:0] d, input logic pt);
      @(negedge clk);
      ifa.p_data     = d;
`ifdef UART_TX_PARITY_EN
      ifa.par_typ    = pt;
`endif
      ifa.data_valid = 1'b1;
      @(negedge clk);
      ifa.data_valid = 1'b0;
   endtask

   // Checks every cycle of a frame on instance A from the current (first start) negedge to the last stop cycle.
   task automatic chk_frame(input logic [7:0] d, input logic pt, input int poke, input string nm);
      for (int idx = 0; idx < NB * CPB_A; idx++) begin
         if (idx > 0) @(negedge clk);
         total++;
         if (ifa.tx_out !== exp_bit(d, pt, idx / CPB_A) || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
            bad++;
            $display("FAIL %s cyc=%0d tx=%b busy=%b done=%b required tx=%b busy=1 done=0",
                     nm, idx, ifa.tx_out, ifa.busy, ifa.done, exp_bit(d, pt, idx / CPB_A));
         end
         if (idx == poke) begin
            ifa.p_data     = 8'h3C;
            ifa.data_valid = 1'b1;
         end else if (idx == poke + 1) begin
            ifa.data_valid = 1'b0;
         end
      end
   endtask

   task automatic chk_done(input string nm);
      @(negedge clk);
      total++;
      if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.tx_out !== 1'b1) begin
         bad++;
         $display("FAIL %s_done done=%b busy=%b tx=%b required 1 0 1", nm, ifa.done, ifa.busy, ifa.tx_out);
      end
   endtask

   task automatic chk_idle(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (ifa.tx_out !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            bad++;
            $display("FAIL %s cyc=%0d tx=%b busy=%b done=%b required 1 0 0", nm, i, ifa.tx_out, ifa.busy, ifa.done);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (ifa.tx_out !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0 ||
          ifb.tx_out !== 1'b1 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
         bad++;
         $display("FAIL reset_state a=%b%b%b b=%b%b%b required 100 100",
                  ifa.tx_out, ifa.busy, ifa.done, ifb.tx_out, ifb.busy, ifb.done);
      end
   endtask

   task automatic test_basic_frame();
      send_a(8'hA5, 1'b0);
      chk_frame(8'hA5, 1'b0, -10, "frame_a5");
      chk_done("frame_a5");
      chk_idle(3, "after_a5");
   endtask

   task automatic test_parity();
      send_a(8'h07, 1'b0);
      chk_frame(8'h07, 1'b0, -10, "par_even_07");
      chk_done("par_even_07");
      chk_idle(2, "after_even");
      send_a(8'h07, 1'b1);
      chk_frame(8'h07, 1'b1, -10, "par_odd_07");
      chk_done("par_odd_07");
      chk_idle(2, "after_odd");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ifa.p_data     = 8'h00;
`ifdef UART_TX_PARITY_EN
      ifa.par_typ    = 1'b0;
`endif
      ifa.data_valid = 1'b1;
      @(negedge clk);
      ifa.p_data = 8'hFF;
      chk_frame(8'h00, 1'b0, -10, "b2b_first");
      chk_done("b2b_first");
      @(negedge clk);
      ifa.data_valid = 1'b0;
      total++;
      if (ifa.tx_out !== 1'b0 || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap tx=%b busy=%b done=%b required 0 1 0", ifa.tx_out, ifa.busy, ifa.done);
      end
      chk_frame(8'hFF, 1'b0, -10, "b2b_second");
      chk_done("b2b_second");
      chk_idle(2, "after_b2b");
   endtask

   task automatic test_ignore_busy();
      send_a(8'hC3, 1'b1);
      chk_frame(8'hC3, 1'b1, 5 * CPB_A + 3, "ignore_c3");
      chk_done("ignore_c3");
      chk_idle(CPB_A * 2, "ignore_no_3c");
   endtask

   task automatic test_reset_mid();
      send_a(8'hA5, 1'b0);
      repeat (CPB_A * 4 + 5) @(negedge clk);
      total++;
      if (ifa.tx_out !== 1'b0 || ifa.busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre tx=%b busy=%b required 0 1", ifa.tx_out, ifa.busy);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (ifa.tx_out !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset tx=%b busy=%b done=%b required 1 0 0", ifa.tx_out, ifa.busy, ifa.done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk_idle(CPB_A * 3, "post_reset_idle");
      send_a(8'h81, 1'b1);
      chk_frame(8'h81, 1'b1, -10, "post_reset_81");
      chk_done("post_reset_81");
      chk_idle(2, "after_81");
   endtask

   task automatic test_scoreboard();
      fork
         begin : drv
            for (int w = 0; w < 20; w++) begin
               logic [7:0] d;
               logic       pt;
               int         t;
               d  = 8'($urandom);
               pt = 1'($urandom_range(0, 1));
               repeat ($urandom_range(0, 3)) @(negedge clk);
               t = 0;
               while (ifb.busy !== 1'b0 && t < 500) begin
                  @(negedge clk);
                  t++;
               end
               sbq.push_back('{d: d, pt: pt});
               ifb.p_data     = d;
`ifdef UART_TX_PARITY_EN
               ifb.par_typ    = pt;
`endif
               ifb.data_valid = 1'b1;
               @(negedge clk);
               ifb.data_valid = 1'b0;
            end
         end
         begin : rcv
            for (int w = 0; w < 20; w++) begin
               logic [7:0] rd;
               logic       rs0;
               logic       rp;
               logic       rstop;
               sb_t        e;
               int         t;
               t  = 0;
               rp = 1'b0;
               while (ifb.tx_out !== 1'b0 && t < 2000) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 2000) begin
                  total++;
                  bad++;
                  $display("FAIL sb_start_timeout word=%0d waited=%0d required start bit", w, t);
                  break;
               end
               repeat (CPB_B / 2) @(negedge clk);
               rs0 = ifb.tx_out;
               for (int b = 0; b < 8; b++) begin
                  repeat (CPB_B) @(negedge clk);
                  rd[b] = ifb.tx_out;
               end
               if (PAR_EN) begin
                  repeat (CPB_B) @(negedge clk);
                  rp = ifb.tx_out;
               end
               repeat (CPB_B) @(negedge clk);
               rstop = ifb.tx_out;
               total++;
               if (sbq.size() == 0) begin
                  bad++;
                  $display("FAIL sb_underflow word=%0d got=%h required queued entry", w, rd);
                  continue;
               end
               e = sbq.pop_front();
               if (rd !== e.d || rs0 !== 1'b0 || rstop !== 1'b1 || (PAR_EN && (rp !== ((^rd) ^ e.pt)))) begin
                  bad++;
                  $display("FAIL sb_word%0d got=%h start=%b par=%b stop=%b required=%h start=0 stop=1 pt=%b",
                           w, rd, rs0, rp, rstop, e.d, e.pt);
               end
            end
         end
      join
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d required 0", sbq.size());
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b0;
      ifa.p_data     = '0;
      ifa.data_valid = 1'b0;
      ifb.p_data     = '0;
      ifb.data_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
      ifa.par_typ    = 1'b0;
      ifb.par_typ    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      chk_idle(3, "idle_after_release");
      test_basic_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_scoreboard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
